// File: rtl/launch_pkg.sv
// launch_pkg
// Shared definitions for the instruction launcher and the PE instruction
// memory side: default instruction geometry and the launcher state encoding.
package launch_pkg;

    // Default instruction word width, program bank depth and PE id width.
    localparam int INST_WIDTH_DEF = 64;
    localparam int INST_WORD_DEF  = 32;
    localparam int ID_W_DEF       = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } launch_state_e;

endpackage

// File: rtl/inst_launcher.sv
// inst_launcher
// Streams a program of len words from an upstream valid/ready source into
// the instruction memory of one target PE.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start_i           launch request (sampled in IDLE only)
//   tgt_id_i          target PE id for the launch
//   len_i             program length in words, legal range 1..INST_WORD
//   in_valid_i        upstream word valid
//   in_ready_o        upstream word ready (STREAM and no abort)
//   in_data_i         upstream word
//   abort_i           cancel the active launch (honoured in STREAM only)
//   valid_o           imem write strobe, same cycle as the accepted handshake
//   id_o              captured target id
//   w_switch_o        bank switch marker, set with the final word's strobe
//   data_o            registered write data (word accepted on previous edge)
//   busy_o            launch in progress (STREAM or DRAIN)
//   done_o            one-cycle completion pulse, high during DRAIN
//   err_o             one-cycle pulse after a start with an illegal length
module inst_launcher
    import launch_pkg::*;
#(
    parameter int INST_WIDTH = INST_WIDTH_DEF,
    parameter int INST_WORD  = INST_WORD_DEF,
    parameter int ID_W       = ID_W_DEF
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start_i,
    input  logic [ID_W-1:0]                tgt_id_i,
    input  logic [$clog2(INST_WORD):0]     len_i,
    input  logic                           in_valid_i,
    output logic                           in_ready_o,
    input  logic [INST_WIDTH-1:0]          in_data_i,
    input  logic                           abort_i,
    output logic                           valid_o,
    output logic [ID_W-1:0]                id_o,
    output logic                           w_switch_o,
    output logic [INST_WIDTH-1:0]          data_o,
    output logic                           busy_o,
    output logic                           done_o,
    output logic                           err_o
);

    localparam int LEN_W = $clog2(INST_WORD) + 1;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(INST_WORD);

    launch_state_e          state_q;
    logic [LEN_W-1:0]       cnt_q;
    logic [LEN_W-1:0]       cnt_d;
    logic [LEN_W-1:0]       len_q;
    logic [ID_W-1:0]        id_q;
    logic [INST_WIDTH-1:0]  data_q;
    logic                   done_q;
    logic                   err_q;

    logic                   accept;
    logic                   last_word;
    logic                   len_bad;

    // Abort blocks the handshake in the same cycle, so a word offered
    // together with abort_i is never accepted or written.
    assign in_ready_o = (state_q == STREAM) && !abort_i;
    assign accept     = in_valid_i && in_ready_o;
    assign last_word  = (cnt_q == len_q - 1'b1);
    assign cnt_d      = cnt_q + 1'b1;
    assign len_bad    = (len_i == '0) || (len_i > MAX_LEN);

    assign valid_o    = accept;
    assign id_o       = id_q;
    assign w_switch_o = accept && last_word;
    assign data_o     = data_q;
    assign busy_o     = (state_q != IDLE);
    assign done_o     = done_q;
    assign err_o      = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            id_q    <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        if (len_bad) begin
                            err_q <= 1'b1;
                        end else begin
                            id_q    <= tgt_id_i;
                            len_q   <= len_i;
                            cnt_q   <= '0;
                            state_q <= STREAM;
                        end
                    end
                end
                STREAM: begin
                    if (abort_i) begin
                        state_q <= IDLE;
                    end else if (accept) begin
                        data_q <= in_data_i;
                        cnt_q  <= cnt_d;
                        // done_q rises with DRAIN so the pulse covers
                        // exactly the cycle data_o shows the last word.
                        if (last_word) begin
                            state_q <= DRAIN;
                            done_q  <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/inst_launcher.md
INST_LAUNCHER -- requirements
Module: inst_launcher

Interface
REQ-001 SHALL have parameters: INST_WIDTH, default 64, instruction word width; INST_WORD, default 32, max words per program bank; ID_W, default 2, PE id width.
REQ-002 SHALL have ports: clk  in  1  clock; rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: start_i  in  1  launch request; tgt_id_i  in  ID_W  target PE id; len_i  in  $clog2(INST_WORD)+1  program length in words.
REQ-004 SHALL have ports: in_valid_i  in  1, in_ready_o  out  1, in_data_i  in  INST_WIDTH  upstream word stream (valid/ready).
REQ-005 SHALL have ports: abort_i  in  1  cancel active launch.
REQ-006 SHALL have ports: valid_o  out  1  write strobe to PE imems; id_o  out  ID_W  target id; w_switch_o  out  1  write-bank switch marker; data_o  out  INST_WIDTH  write data.
REQ-007 SHALL have ports: busy_o  out  1  launch in progress; done_o  out  1  one-cycle completion pulse; err_o  out  1  one-cycle bad-request pulse.

Function
REQ-008 SHALL implement states IDLE, STREAM, DRAIN.
REQ-009 In IDLE, start_i with 1 <= len_i <= INST_WORD SHALL capture tgt_id_i and len_i, clear the word counter, and enter STREAM next cycle.
REQ-010 In IDLE, start_i with len_i == 0 or len_i > INST_WORD SHALL pulse err_o for one cycle and remain in IDLE.
REQ-011 start_i outside IDLE SHALL be ignored (no err_o).
REQ-012 in_ready_o SHALL be 1 only in STREAM with abort_i low; a word is accepted when in_valid_i & in_ready_o.
REQ-013 Each accepted word SHALL drive valid_o=1 and id_o=captured id in the same cycle (combinational from the handshake); otherwise valid_o=0.
REQ-014 data_o SHALL be registered: the word accepted in cycle t is presented on data_o in cycle t+1 and held until the next accepted word.
REQ-015 w_switch_o SHALL equal 1 exactly with valid_o of the final (len-th) word, else 0.
REQ-016 After the final word is accepted, state SHALL go to DRAIN for exactly one cycle (data_o carries the last word), then IDLE with done_o pulsed in the DRAIN cycle.
REQ-017 Word counter SHALL be $clog2(INST_WORD)+1 bits; it never wraps because len_i <= INST_WORD.
REQ-018 in_valid_i low in STREAM SHALL stall without emitting valid_o; no timeout.
REQ-019 abort_i in STREAM SHALL return to IDLE next cycle, emit no valid_o/w_switch_o that cycle, and not pulse done_o; abort_i coincident with the final word SHALL win (word not accepted).
REQ-020 abort_i in IDLE or DRAIN SHALL be ignored.
REQ-021 busy_o SHALL be 1 in STREAM and DRAIN, 0 in IDLE.

Reset
REQ-022 On rst_n low: state IDLE, counter 0, captured id/len 0, data_o 0; valid_o, w_switch_o, in_ready_o, busy_o, done_o, err_o all 0.
REQ-023 Reset asserted mid-STREAM SHALL abandon the launch with no further valid_o; no w_switch_o emitted.

Structure
REQ-024 State enum and INST_WIDTH/INST_WORD/ID_W defaults SHALL live in a shared package launch_pkg, shared with the imem side.
REQ-025 Single module; no sub-module required.

Verification
REQ-026 start, id=3, len=4, words A0..A3 back-to-back -> valid_o cycles t..t+3, id_o=3, data_o A0..A3 in t+1..t+4, w_switch_o only at t+3, done_o at t+4.
REQ-027 len=32 with in_valid_i gapped every other cycle -> 32 valid_o pulses, no valid_o during gaps, single w_switch_o on word 32.
REQ-028 start with len=0, then len=33 -> err_o pulse each, state stays IDLE, busy_o=0, valid_o never asserts.
REQ-029 len=8, abort_i asserted coincident with word 5 -> 4 valid_o pulses, no w_switch_o, no done_o, IDLE next cycle.
REQ-030 start_i asserted during STREAM with different id -> ignored, current launch completes with original id.
REQ-031 rst_n low after word 2 of len=6 -> all outputs 0 immediately; new start after release runs cleanly.
